// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: drives program-memory address, latches the returned
// instruction into ir and offers it to execute over a valid/ready handshake.
module fetch_sequencer #(
   parameter int ADDR_W = 5,
   parameter int INS_W  = 13,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   input  logic              stop,
   input  logic              restart,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [INS_W-1:0]  mem_ins,
   output logic [INS_W-1:0]  ir,
   output logic              ir_valid,
   input  logic              ex_ready,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              wrap,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   pc_n;
   logic [INS_W-1:0]    ir_n;
   logic                ir_valid_n;
   logic                wrap_n;
   logic [CNT_W-1:0]    retired_n;
   logic                step_flag, step_flag_n;
   logic                stop_pend, stop_pend_n;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign mem_addr = pc;

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      ir_n        = ir;
      ir_valid_n  = ir_valid;
      wrap_n      = 1'b0;
      retired_n   = retired;
      step_flag_n = step_flag;
      stop_pend_n = stop_pend;
      case (state)
         IDLE, HALT: begin
            if (restart) pc_n = '0;
            // stop wins even though it has nothing to halt here
            if (!stop) begin
               if (step) begin
                  state_n     = FETCH;
                  step_flag_n = 1'b1;
               end else if (start) begin
                  state_n     = FETCH;
                  step_flag_n = 1'b0;
               end
            end
         end
         FETCH: begin
            ir_n       = mem_ins;
            ir_valid_n = 1'b1;
            pc_n       = pc + ADDR_W'(1);
            wrap_n     = (pc == {ADDR_W{1'b1}});
            if (stop) stop_pend_n = 1'b1;
            state_n    = ISSUE;
         end
         ISSUE: begin
            if (stop) stop_pend_n = 1'b1;
            if (ir_valid && ex_ready) begin
               retired_n  = sat_inc(retired);
               ir_valid_n = 1'b0;
               if (jmp_en) pc_n = jmp_addr;
               // a stop landing on the handshake cycle still halts after this one
               if (step_flag || stop_pend || stop) begin
                  state_n     = HALT;
                  stop_pend_n = 1'b0;
               end else begin
                  state_n = FETCH;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= '0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         wrap      <= 1'b0;
         retired   <= '0;
         halted    <= 1'b1;
         step_flag <= 1'b0;
         stop_pend <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         ir        <= ir_n;
         ir_valid  <= ir_valid_n;
         wrap      <= wrap_n;
         retired   <= retired_n;
         halted    <= (state_n == IDLE) || (state_n == HALT);
         step_flag <= step_flag_n;
         stop_pend <= stop_pend_n;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected instructions,
// a negedge monitor checks each handshake against them.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, step, stop, restart;
   logic [4:0]  mem_addr;
   logic [12:0] mem_ins;
   logic [12:0] ir;
   logic        ir_valid;
   logic        ex_ready;
   logic        jmp_en;
   logic [4:0]  jmp_addr;
   logic [4:0]  pc;
   logic        halted;
   logic        wrap;
   logic [7:0]  retired;

   logic [12:0] mem [32];
   logic [12:0] q [$];
   int          errors = 0;
   int          checks = 0;

   fetch_sequencer #(.ADDR_W(5), .INS_W(13), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
      .restart(restart), .mem_addr(mem_addr), .mem_ins(mem_ins), .ir(ir),
      .ir_valid(ir_valid), .ex_ready(ex_ready), .jmp_en(jmp_en),
      .jmp_addr(jmp_addr), .pc(pc), .halted(halted), .wrap(wrap),
      .retired(retired)
   );

   always #5 clk = ~clk;
   assign mem_ins = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && ir_valid && ex_ready) begin
         chk("sb_nonempty", q.size() > 0, 1);
         if (q.size() > 0) chk("handshake_ir", ir, q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      mem[0] = 13'h0101;   // {ADD, R1}
      mem[1] = 13'h0201;   // {SUB, R1}
      for (int i = 2; i < 32; i++) mem[i] = {5'(i + 3), 8'(i * 7 + 5)};
      start = 0; step = 0; stop = 0; restart = 0;
      ex_ready = 1; jmp_en = 0; jmp_addr = 0;
      rst_n = 0;
      #12;
      chk("rst_ir", ir, 0);
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_pc", pc, 0);
      chk("rst_halted", halted, 1);
      chk("rst_retired", retired, 0);
      chk("rst_wrap", wrap, 0);
      @(negedge clk); rst_n = 1;
      tick();

      // continuous run, stop raised during the second FETCH
      q.push_back(mem[0]); q.push_back(mem[1]);
      start = 1; tick(); start = 0;
      chk("run_fetch_no_valid", ir_valid, 0);
      tick();
      chk("run_ir0_valid", ir_valid, 1);
      chk("run_ir0", ir, mem[0]);
      chk("run_pc1", pc, 1);
      tick();
      stop = 1; tick(); stop = 0;
      chk("run_ir1", ir, mem[1]);
      tick();
      chk("run_halted", halted, 1);
      chk("run_retired2", retired, 2);
      chk("run_pc2", pc, 2);
      chk("run_ir_valid_off", ir_valid, 0);

      // restart then single steps
      restart = 1; tick(); restart = 0;
      chk("restart_pc0", pc, 0);
      q.push_back(mem[0]);
      step = 1; tick(); step = 0;
      tick(); tick();
      chk("step1_halted", halted, 1);
      chk("step1_pc", pc, 1);
      chk("step1_retired", retired, 3);
      tick(); tick(); tick();
      chk("step1_idle_valid", ir_valid, 0);
      chk("step1_idle_pc", pc, 1);
      q.push_back(mem[1]);
      step = 1; tick(); step = 0;
      tick(); tick();
      chk("step2_pc", pc, 2);
      chk("step2_retired", retired, 4);
      chk("step2_halted", halted, 1);

      // backpressure with stop mid-stall
      ex_ready = 0;
      q.push_back(mem[2]);
      start = 1; tick(); start = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_ir", ir, mem[2]);
         chk("stall_valid", ir_valid, 1);
         stop = (i == 2);
         tick();
      end
      stop = 0; ex_ready = 1;
      tick();
      chk("bp_halted", halted, 1);
      chk("bp_retired", retired, 5);
      tick(); tick(); tick();
      chk("bp_pc_hold", pc, 3);
      chk("bp_valid_off", ir_valid, 0);

      // jump to 31 then wrap
      q.push_back(mem[3]);
      start = 1; tick(); start = 0;
      jmp_en = 1; jmp_addr = 31;
      tick();
      chk("jmp_in_fetch_ignored", pc, 4);
      tick();
      jmp_en = 0;
      chk("jmp_pc31", pc, 31);
      chk("jmp_no_wrap", wrap, 0);
      q.push_back(mem[31]);
      tick();
      chk("jmp_ir31", ir, mem[31]);
      chk("wrap_pc0", pc, 0);
      chk("wrap_pulse", wrap, 1);
      stop = 1; tick(); stop = 0;
      chk("wrap_once", wrap, 0);
      chk("wrap_halted", halted, 1);
      chk("wrap_retired", retired, 7);

      // simultaneous commands
      stop = 1; step = 1; tick(); stop = 0; step = 0;
      tick();
      chk("stopstep_halted", halted, 1);
      chk("stopstep_pc", pc, 0);
      chk("stopstep_valid", ir_valid, 0);
      q.push_back(mem[0]);
      start = 1; step = 1; tick(); start = 0; step = 0;
      tick(); tick();
      chk("startstep_halted", halted, 1);
      chk("startstep_pc", pc, 1);
      chk("startstep_retired", retired, 8);
      tick(); tick();
      chk("startstep_stays", ir_valid, 0);
      q.push_back(mem[1]);
      step = 1; tick(); step = 0;
      jmp_en = 1; jmp_addr = 9;
      tick(); tick();
      jmp_en = 0;
      chk("step_jmp_pc9", pc, 9);
      chk("step_jmp_halted", halted, 1);
      restart = 1; tick(); restart = 0;
      chk("restart_pc9_to_0", pc, 0);

      // asynchronous reset while an instruction is offered
      ex_ready = 0;
      start = 1; tick(); start = 0;
      tick();
      chk("pre_arst_valid", ir_valid, 1);
      #2;
      rst_n = 0;
      #1;
      chk("arst_ir", ir, 0);
      chk("arst_valid", ir_valid, 0);
      chk("arst_pc", pc, 0);
      chk("arst_halted", halted, 1);
      chk("arst_retired", retired, 0);
      chk("arst_wrap", wrap, 0);
      @(negedge clk); rst_n = 1;
      tick();
      ex_ready = 1;
      q.push_back(mem[0]);
      start = 1; tick(); start = 0;
      stop = 1; tick(); stop = 0;
      tick();
      chk("resume_pc", pc, 1);
      chk("resume_retired", retired, 1);
      chk("resume_halted", halted, 1);
      tick(); tick();
      chk("sb_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
